// File: rtl/secded_pipe_decoder.sv
// Pipelined SEC-DED Hamming decoder with valid/ready flow control and saturating error counters.
// S1 registers the syndrome and overall parity; S2 applies the correction and drives the outputs.
module secded_pipe_decoder #(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int R      = (DATA_W <= 4)  ? 3 :
                          (DATA_W <= 11) ? 4 :
                          (DATA_W <= 26) ? 5 :
                          (DATA_W <= 57) ? 6 : 7,
  localparam int CHK_W  = R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              corr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ce,
  output logic              out_ue,
  output logic [R-1:0]      out_syn,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt
);

  // Codeword position of data bit j: the j-th position that is not a power of two.
  function automatic int data_pos(input int j);
    int n;
    data_pos = 0;
    n = 0;
    for (int q = 1; q < 128; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (n == j) data_pos = q;
        n = n + 1;
      end
    end
  endfunction

  localparam logic [R-1:0] MAX_POS = R'(DATA_W + R);

  logic [R-1:0]      w_dterm [DATA_W];
  logic [DATA_W-1:0] w_flip;
  logic [R-1:0]      w_syn;
  logic              w_par;
  logic              w_s2_load, w_s1_adv, w_in_fire, w_out_fire;
  logic              w_big, w_ce, w_ue;

  logic              r1_valid, r1_par, r1_corr;
  logic [DATA_W-1:0] r1_data;
  logic [R-1:0]      r1_syn;
  logic              r2_valid, r2_ce, r2_ue;
  logic [DATA_W-1:0] r2_data;
  logic [R-1:0]      r2_syn;
  logic [CNT_W-1:0]  r_ce_cnt, r_ue_cnt;

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
      localparam logic [R-1:0] P = R'(data_pos(gi));
      assign w_dterm[gi] = in_data[gi] ? P : '0;
      assign w_flip[gi]  = r1_par & r1_corr & (r1_syn == P);
    end
  endgenerate

  // Check bit i sits at position 2^i, so it toggles syndrome bit i only.
  always_comb begin
    w_syn = in_chk[R-1:0];
    for (int i = 0; i < DATA_W; i++) w_syn = w_syn ^ w_dterm[i];
  end
  assign w_par = ^{in_data, in_chk};

  assign w_s2_load  = !r2_valid | out_ready;
  assign w_s1_adv   = r1_valid & w_s2_load;
  assign in_ready   = !r1_valid | w_s1_adv;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r2_valid & out_ready;

  assign w_big = r1_syn > MAX_POS;
  assign w_ce  = r1_par & !w_big;
  assign w_ue  = r1_par ? w_big : (r1_syn != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_data  <= '0;
      r1_syn   <= '0;
      r1_par   <= 1'b0;
      r1_corr  <= 1'b0;
    end else if (w_in_fire) begin
      r1_valid <= 1'b1;
      r1_data  <= in_data;
      r1_syn   <= w_syn;
      r1_par   <= w_par;
      r1_corr  <= corr_en;
    end else if (w_s1_adv) begin
      r1_valid <= 1'b0;
    end
  end

  // Payload only moves on a real beat so a stalled output stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_data  <= '0;
      r2_ce    <= 1'b0;
      r2_ue    <= 1'b0;
      r2_syn   <= '0;
    end else if (w_s2_load) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_data <= r1_data ^ w_flip;
        r2_ce   <= w_ce;
        r2_ue   <= w_ue;
        r2_syn  <= r1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      r_ce_cnt <= '0;
      r_ue_cnt <= '0;
    end else begin
      if (w_out_fire && r2_ce && (r_ce_cnt != '1)) r_ce_cnt <= r_ce_cnt + 1'b1;
      if (w_out_fire && r2_ue && (r_ue_cnt != '1)) r_ue_cnt <= r_ue_cnt + 1'b1;
    end
  end

  assign out_valid = r2_valid;
  assign out_data  = r2_data;
  assign out_ce    = r2_ce;
  assign out_ue    = r2_ue;
  assign out_syn   = r2_syn;
  assign ce_cnt    = r_ce_cnt;
  assign ue_cnt    = r_ue_cnt;

endmodule

// File: tb/tb_secded_pipe_decoder.sv
// Scoreboard bench for secded_pipe_decoder (DATA_W=32, CNT_W=4): directed beats push expectations,
// a negedge monitor pops and compares every output transfer.
module tb_secded_pipe_decoder;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [6:0]    in_chk = '0;
  logic          corr_en = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_ce, out_ue;
  logic [5:0]    out_syn;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] ce_cnt, ue_cnt;

  secded_pipe_decoder #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk), .corr_en(corr_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ce(out_ce), .out_ue(out_ue), .out_syn(out_syn),
    .clr_cnt(clr_cnt), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        ce;
    logic        ue;
    logic [5:0]  syn;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   n_acc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reference encoder: data fills non-power-of-two positions 1..38 in order.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] c;
    int n;
    c = '0;
    n = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[n]) begin
          for (int i = 0; i < 6; i++) if (p[i]) c[i] = ~c[i];
        end
        n++;
      end
    end
    c[6] = ^d ^ ^c[5:0];
    return c;
  endfunction

  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic corr,
                      input logic [31:0] ed, input logic ece, input logic eue, input logic [5:0] esyn);
    int t;
    exp_t e;
    @(negedge clk);
    in_data = d; in_chk = c; corr_en = corr; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: in_ready=0 required 1");
      in_valid = 1'b0;
      return;
    end
    e.d = ed; e.ce = ece; e.ue = eue; e.syn = esyn;
    q.push_back(e);
    @(posedge clk);
    n_acc++;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_vec++; n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding required 0", q.size());
    end
    @(negedge clk);
  endtask

  // Monitor: compare each output transfer and check payload stability under stall.
  logic        held = 1'b0;
  logic [40:0] prev;
  exp_t        e_mon;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid)
        check("hold_stable", {23'd0, out_data, out_ce, out_ue, out_syn}, {23'd0, prev});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_beat: data %0h with no beat outstanding", out_data);
        end else begin
          e_mon = q.pop_front();
          check("out_data", {32'd0, out_data}, {32'd0, e_mon.d});
          check("ce_ue_syn", {56'd0, out_ce, out_ue, out_syn}, {56'd0, e_mon.ce, e_mon.ue, e_mon.syn});
        end
      end
      held = out_valid && !out_ready;
      prev = {out_data, out_ce, out_ue, out_syn};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] w;
  logic [6:0]  c;
  int          t;
  int          base;

  initial begin
    w = 32'hDEADBEEF;
    c = enc(w);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_outputs", {24'd0, out_data, out_ce, out_ue, out_syn}, 64'd0);
    check("rst_counters", {56'd0, ce_cnt, ue_cnt}, 64'd0);

    @(posedge clk); #1 out_ready = 1'b1;
    send(w, c, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    check("latency_k1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    check("latency_k2_valid", {63'd0, out_valid}, 64'd1);
    wait_drain();

    send(w ^ 32'h20, c, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 6'd10);
    wait_drain();
    check("ce_cnt_1", {60'd0, ce_cnt}, 64'd1);
    send(w ^ 32'h20, c, 1'b0, 32'hDEADBECF, 1'b1, 1'b0, 6'd10);
    send(w ^ 32'h3, c, 1'b1, 32'hDEADBEEC, 1'b0, 1'b1, 6'd6);
    wait_drain();
    check("ue_cnt_1", {60'd0, ue_cnt}, 64'd1);
    send(w, c ^ 7'h40, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 6'd0);
    send(w, c ^ 7'h04, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 6'd4);
    // data[31] (pos 38) + chk[0] (pos 1) + overall bit: syndrome 39 is beyond the codeword
    send(w ^ 32'h80000000, c ^ 7'h41, 1'b1, 32'h5EADBEEF, 1'b0, 1'b1, 6'd39);
    wait_drain();
    check("counts_mix", {56'd0, ce_cnt, ue_cnt}, {56'd0, 4'd4, 4'd2});

    // Back-to-back with a stalled consumer
    @(posedge clk); #1 out_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          w = 32'(i);
          send(w, enc(w), 1'b1, w, 1'b0, 1'b0, 6'd0);
        end
      end
      begin
        t = 0;
        while (n_acc < base + 2 && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("stall_in_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Saturation at 15 with CNT_W=4
    @(posedge clk); #1 clr_cnt = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_counters", {56'd0, ce_cnt, ue_cnt}, 64'd0);
    for (int i = 0; i < 17; i++) begin
      w = 32'h01010101 * 32'(i);
      send(w ^ 32'h20, enc(w), 1'b1, w, 1'b1, 1'b0, 6'd10);
    end
    wait_drain();
    check("ce_cnt_sat", {60'd0, ce_cnt}, 64'd15);

    // Clear coinciding with a CE output transfer
    @(posedge clk); #1 out_ready = 1'b0;
    w = 32'hA5A5A5A5;
    send(w ^ 32'h20, enc(w), 1'b1, w, 1'b1, 1'b0, 6'd10);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("clr_pre_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1 clr_cnt = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_wins", {60'd0, ce_cnt}, 64'd0);
    wait_drain();

    // Reset with both stages full
    w = 32'hDEADBEEF;
    send(w ^ 32'h3, enc(w), 1'b1, 32'hDEADBEEC, 1'b0, 1'b1, 6'd6);
    wait_drain();
    check("ue_before_rst", {60'd0, ue_cnt}, 64'd1);
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h11, enc(32'h11), 1'b1, 32'h11, 1'b0, 1'b0, 6'd0);
    send(32'h22, enc(32'h22), 1'b1, 32'h22, 1'b0, 1'b0, 6'd0);
    @(negedge clk);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1 rst = 1'b1; q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_counters", {56'd0, ce_cnt, ue_cnt}, 64'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h12345678, enc(32'h12345678), 1'b1, 32'h12345678, 1'b0, 1'b0, 6'd0);
    wait_drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/secded_pipe_decoder.md
Name: secded_pipe_decoder

Overview:
- Parametrised, pipelined single-error-correct / double-error-detect (SEC-DED) decoder.
- Successor to the team's fixed 32-bit combinational error-correction circuit: any data width, valid/ready flow control, a correction-enable mode, per-beat error flags and saturating error counters.
- Sits between protected storage or links and consumers in the fault-tolerant datapath.

Parameters:
- DATA_W, 32: data bits per beat (4..64).
- R, derived (not overridable): smallest r with 2^r >= DATA_W + r + 1 (DATA_W=32 gives R=6).
- CHK_W, derived (not overridable): R+1 (DATA_W=32 gives CHK_W=7).
- CNT_W, 16: width of each error counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  decoder can accept a beat.
- in_data  in  DATA_W  received data.
- in_chk  in  CHK_W  received check bits.
- corr_en  in  1  1 = correct single errors; 0 = detect only. Sampled with each beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DATA_W  corrected data; raw data when uncorrected.
- out_ce  out  1  correctable error detected on this beat.
- out_ue  out  1  uncorrectable error detected on this beat.
- out_syn  out  R  Hamming syndrome of this beat.
- clr_cnt  in  1  synchronous clear of both counters.
- ce_cnt  out  CNT_W  saturating count of CE beats.
- ue_cnt  out  CNT_W  saturating count of UE beats.

Behaviour:
- Code layout: codeword positions 1..DATA_W+R.
  - Check bit in_chk[i] (i<R) occupies position 2^i.
  - Data bits fill the remaining positions in ascending order: data[0]@3, data[1]@5, data[2]@6, data[3]@7, data[4]@9, and so on.
  - in_chk[i] = XOR of every position p>=1 whose bit i is set (even parity).
  - in_chk[R] = XOR of all data bits and in_chk[R-1:0].
- Decode rules:
  - syn = XOR of the positions of all set codeword bits, including check bits.
  - par = XOR of all data bits and all CHK_W check bits.
  - syn=0, par=0: no error; ce=0, ue=0.
  - par=1, syn=0: overall-parity bit error; ce=1; data unchanged.
  - par=1, syn names a check position: ce=1; data unchanged.
  - par=1, syn names a data position: ce=1; that data bit is flipped only if the beat's corr_en=1.
  - par=1, syn>DATA_W+R: ue=1, ce=0; data raw.
  - par=0, syn!=0: ue=1, ce=0; data raw.
  - ce and ue are never both 1.
- Pipeline: two register stages.
  - S1 captures data, syndrome, parity and corr_en.
  - S2 holds corrected data and flags and drives the out_* ports.
  - Latency: a beat accepted at edge k is presented with out_valid=1 after edge k+2 when not stalled.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - A stage loads when it is empty or its content transfers in the same cycle.
  - in_ready = !S1_full | S1 advancing. The combinational path from out_ready to in_ready is allowed.
  - Full throughput: one beat per cycle with out_ready held high.
  - out_* fields are stable while out_valid=1 and out_ready=0.
  - No beat is dropped, duplicated or reordered.
  - in_data is don't-care when in_valid=0.
- Counters:
  - ce_cnt increments on each output transfer with out_ce=1; ue_cnt on each output transfer with out_ue=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 sets both to 0 next edge; when clr_cnt and an increment coincide, clear wins.
- Reset values: both stages empty; out_valid=0, in_ready=1 on the first cycle after reset; out_data=0, out_ce=0, out_ue=0, out_syn=0, ce_cnt=0, ue_cnt=0.
- Reset mid-operation discards all in-flight beats; counters return to 0.
- rst has priority over every other input.

Test Plan:
- DATA_W=32: encode 0xDEADBEEF with the bench reference encoder, no flips, out_ready=1 -> out_data=0xDEADBEEF, ce=0, ue=0, syn=0, out_valid 2 cycles after acceptance.
- Same word, data[5] flipped (position 10), corr_en=1 -> out_data=0xDEADBEEF, ce=1, syn=10, ce_cnt=1. Repeat with corr_en=0 -> out_data=0xDEADBECF, ce=1.
- Flip data[0] and data[1] -> ue=1, ce=0, out_data=0xDEADBEEC, ue_cnt=1. Flip in_chk[6] alone -> ce=1, syn=0, data unchanged.
- Send 4 back-to-back beats (0x1, 0x2, 0x3, 0x4) with out_ready=0 for 5 cycles -> in_ready=0 after 2 beats held, then 0x1..0x4 delivered in order, each exactly once.
- CNT_W=4: send 17 single-error beats -> ce_cnt=15. Then assert clr_cnt in the same cycle as a CE output transfer -> ce_cnt=0.
- Assert rst with both stages full -> next cycle out_valid=0, counters=0, in_ready=1; the next accepted beat emerges normally.
